// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA constants: 640x480@60 raster timing, counter/coordinate widths,
// and the colour/address widths used by the downstream image RAM and colour mux.
package vga_timing_gen_pkg;

    localparam int WIDTH   = 640;
    localparam int HEIGHT  = 480;
    localparam int H_FRONT = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int V_FRONT = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;

    localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

    localparam int CNT_W = 10;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    localparam int COLOR_W    = 12;
    localparam int PIX_ADDR_W = $clog2(WIDTH * HEIGHT);
    localparam int PAL_ADDR_W = 8;

    typedef logic [COLOR_W-1:0] color_t;

    typedef struct packed {
        logic           active;
        logic           h_sync;
        logic           v_sync;
        logic           screen_end;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } vga_timing_t;

    // Half-open window test [lo, hi) on a raster counter.
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Wrap-at-N counter with enable; o_wrap flags the enabled cycle that returns
// the count to zero so it can chain into the next counter.
module mod_counter #(
    parameter int N = 800,
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_count <= '0;
        else if (i_en)
            r_count <= o_wrap ? '0 : r_count + W'(1);
    end

    assign o_wrap  = i_en && (r_count == LAST);
    assign o_count = r_count;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: chained h/v counters with purely
// combinational sync/active/coordinate decodes (zero latency to the counters).
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int P_WIDTH   = WIDTH,
    parameter int P_HEIGHT  = HEIGHT,
    parameter int P_H_FRONT = H_FRONT,
    parameter int P_H_SYNC  = H_SYNC,
    parameter int P_H_BACK  = H_BACK,
    parameter int P_V_FRONT = V_FRONT,
    parameter int P_V_SYNC  = V_SYNC,
    parameter int P_V_BACK  = V_BACK
) (
    input  logic           clk25,
    input  logic           reset,
    output logic           screenEnd,
    output logic           active,
    output logic           hSync,
    output logic           vSync,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y
);

    localparam int P_H_TOTAL = P_WIDTH + P_H_FRONT + P_H_SYNC + P_H_BACK;
    localparam int P_V_TOTAL = P_HEIGHT + P_V_FRONT + P_V_SYNC + P_V_BACK;

    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(P_WIDTH);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(P_WIDTH + P_H_FRONT);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(P_WIDTH + P_H_FRONT + P_H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(P_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(P_HEIGHT);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(P_HEIGHT + P_V_FRONT);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(P_HEIGHT + P_V_FRONT + P_V_SYNC);
    localparam logic [Y_W-1:0]   Y_MAX  = Y_W'(P_HEIGHT - 1);

    logic [CNT_W-1:0] w_hcount;
    logic [CNT_W-1:0] w_vcount;
    logic             w_hwrap;
    logic             w_vwrap;
    vga_timing_t      w_tim;

    mod_counter #(.N(P_H_TOTAL), .W(CNT_W)) u_hcnt (
        .i_clk   (clk25),
        .i_reset (reset),
        .i_en    (1'b1),
        .o_count (w_hcount),
        .o_wrap  (w_hwrap)
    );

    // Vertical advances only on the last pixel of each line.
    mod_counter #(.N(P_V_TOTAL), .W(CNT_W)) u_vcnt (
        .i_clk   (clk25),
        .i_reset (reset),
        .i_en    (w_hwrap),
        .o_count (w_vcount),
        .o_wrap  (w_vwrap)
    );

    // Frame wrap must coincide with the final pixel of the final line.
    always_ff @(posedge clk25) begin
        if (!reset && w_vwrap)
            assert (w_hcount == H_LAST);
    end

    always_comb begin
        w_tim            = '0;
        w_tim.active     = (w_hcount < H_VIS) && (w_vcount < V_VIS);
        w_tim.h_sync     = !in_window(w_hcount, H_SS, H_SE);
        w_tim.v_sync     = !in_window(w_vcount, V_SS, V_SE);
        w_tim.screen_end = (w_hcount == '0) && (w_vcount == V_VIS);
        w_tim.x          = w_hcount;
        // Saturate in vertical blanking so y never leaves the image.
        w_tim.y          = (w_vcount < V_VIS) ? w_vcount[Y_W-1:0] : Y_MAX;
    end

    assign active    = w_tim.active;
    assign hSync     = w_tim.h_sync;
    assign vSync     = w_tim.v_sync;
    assign screenEnd = w_tim.screen_end;
    assign x         = w_tim.x;
    assign y         = w_tim.y;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size instance checks reset and one line; a reduced-geometry
// instance checks whole-frame behaviour, screenEnd spacing and mid-frame reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic       se;
        logic [9:0] x;
        logic [8:0] y;
    } obs_t;

    logic       clk25 = 1'b0;
    logic       rst_f, rst_s;
    logic       se_f, act_f, hs_f, vs_f;
    logic       se_s, act_s, hs_s, vs_s;
    logic [9:0] x_f, x_s;
    logic [8:0] y_f, y_s;
    obs_t       obs_f, obs_s;

    int n_cmp = 0;
    int n_mis = 0;
    obs_t q[$];

    always #20 clk25 = ~clk25;

    vga_timing_gen dut_f (
        .clk25(clk25), .reset(rst_f), .screenEnd(se_f), .active(act_f),
        .hSync(hs_f), .vSync(vs_f), .x(x_f), .y(y_f)
    );

    // Small raster: 23 pixels/line, 15 lines/frame, 345 cycles/frame.
    vga_timing_gen #(
        .P_WIDTH(16), .P_HEIGHT(8), .P_H_FRONT(2), .P_H_SYNC(3), .P_H_BACK(2),
        .P_V_FRONT(2), .P_V_SYNC(2), .P_V_BACK(3)
    ) dut_s (
        .clk25(clk25), .reset(rst_s), .screenEnd(se_s), .active(act_s),
        .hSync(hs_s), .vSync(vs_s), .x(x_s), .y(y_s)
    );

    always_comb begin
        obs_f = '{act: act_f, hs: hs_f, vs: vs_f, se: se_f, x: x_f, y: y_f};
        obs_s = '{act: act_s, hs: hs_s, vs: vs_s, se: se_s, x: x_s, y: y_s};
    end

    // Expected outputs for the n-th cycle after reset, from absolute position.
    function automatic obs_t model(input int n, input int w, input int hf, input int hsw,
                                   input int hb, input int h, input int vf, input int vsw,
                                   input int vb);
        obs_t m;
        int ht = w + hf + hsw + hb;
        int vt = h + vf + vsw + vb;
        int hc = n % ht;
        int vc = (n / ht) % vt;
        m.act = (hc < w) && (vc < h);
        m.hs  = !((hc >= w + hf) && (hc < w + hf + hsw));
        m.vs  = !((vc >= h + vf) && (vc < h + vf + vsw));
        m.se  = (hc == 0) && (vc == h);
        m.x   = 10'(hc);
        m.y   = (vc < h) ? 9'(vc) : 9'(h - 1);
        return m;
    endfunction

    task automatic check_q(input string tag, input obs_t got, input int n);
        obs_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_mis++;
            $error("FAIL %s n=%0d scoreboard empty", tag, n);
        end else begin
            e = q.pop_front();
            assert (got === e) else begin
                n_mis++;
                $error("FAIL %s n=%0d got act=%b hs=%b vs=%b se=%b x=%0d y=%0d exp act=%b hs=%b vs=%b se=%b x=%0d y=%0d",
                       tag, n, got.act, got.hs, got.vs, got.se, got.x, got.y,
                       e.act, e.hs, e.vs, e.se, e.x, e.y);
            end
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        obs_t rst_exp;
        int act_cnt, hs_cnt, hs_first, vs_cnt, se_cnt, se_a, se_b, se_after;

        rst_exp = '{act: 1'b1, hs: 1'b1, vs: 1'b1, se: 1'b0, x: 10'd0, y: 9'd0};
        rst_f = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(posedge clk25);
        @(negedge clk25);
        rst_f = 1'b0;

        // Reset state and one full-size line.
        chk_int("rst_state", int'(obs_f), int'(rst_exp));
        act_cnt = 0; hs_cnt = 0; hs_first = -1;
        for (int n = 0; n <= 800; n++) begin
            q.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33));
            if (n > 0) @(negedge clk25);
            check_q("line", obs_f, n);
            if (n < 800) begin
                if (obs_f.act) act_cnt++;
                if (!obs_f.hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = n;
                end
            end
        end
        chk_int("line_active", act_cnt, 640);
        chk_int("line_hs_len", hs_cnt, 96);
        chk_int("line_hs_start", hs_first, 656);
        chk_int("wrap_x", int'(x_f), 0);
        chk_int("wrap_y", int'(y_f), 1);

        // Two small frames plus a partial one up to (h=10, v=5).
        rst_s = 1'b0;
        act_cnt = 0; vs_cnt = 0; hs_cnt = 0; se_cnt = 0; se_a = -1; se_b = -1;
        for (int n = 0; n <= 815; n++) begin
            q.push_back(model(n, 16, 2, 3, 2, 8, 2, 2, 3));
            if (n > 0) @(negedge clk25);
            check_q("frame", obs_s, n);
            if (n < 345) begin
                if (obs_s.act) act_cnt++;
                if (!obs_s.vs) vs_cnt++;
            end
            if (n < 23 && !obs_s.hs) hs_cnt++;
            if (n < 690 && obs_s.se) begin
                se_cnt++;
                if (se_a < 0) se_a = n; else if (se_b < 0) se_b = n;
            end
        end
        chk_int("frame_active", act_cnt, 128);
        chk_int("frame_vs_len", vs_cnt, 46);
        chk_int("small_hs_len", hs_cnt, 3);
        chk_int("se_count", se_cnt, 2);
        chk_int("se_first", se_a, 184);
        chk_int("se_second", se_b, 529);
        chk_int("mid_x", int'(x_s), 10);
        chk_int("mid_y", int'(y_s), 5);

        // Mid-frame reset restarts at (0,0).
        rst_s = 1'b1;
        q.push_back(model(0, 16, 2, 3, 2, 8, 2, 2, 3));
        @(negedge clk25);
        check_q("midrst", obs_s, 0);
        rst_s = 1'b0;
        se_after = -1;
        for (int n = 1; n <= 200; n++) begin
            q.push_back(model(n, 16, 2, 3, 2, 8, 2, 2, 3));
            @(negedge clk25);
            check_q("after_rst", obs_s, n);
            if (obs_s.se && se_after < 0) se_after = n;
        end
        chk_int("se_after_rst", se_after, 184);
        chk_int("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator for the VGA display path. It runs on the 25 MHz pixel clock and scans a full 640x480@60 Hz frame, including blanking. It produces active-low horizontal and vertical sync, an active-video flag, the current pixel coordinates, and a one-cycle end-of-frame pulse. Downstream logic (image RAM address, bounds checks, colour mux) consumes x/y/active; hSync/vSync go straight to the connector.

Parameters:
WIDTH, 640, visible pixels per line
HEIGHT, 480, visible lines per frame
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk25  input  1  pixel clock, 25 MHz, all logic on rising edge
reset  input  1  synchronous, active-high reset
screenEnd  output  1  one-cycle pulse at start of vertical blanking
active  output  1  high while the current pixel is visible
hSync  output  1  horizontal sync, active low
vSync  output  1  vertical sync, active low
x  output  10  current column
y  output  9  current row, saturated in vertical blanking

Behaviour:
- One clock (clk25). Reset is synchronous and active-high, sampled on the rising edge of clk25.
- Derived totals: H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK = 525.
- Internal counters: hcount (10 bits, 0..H_TOTAL-1) and vcount (10 bits, 0..V_TOTAL-1).
- Each clk25 edge without reset:
  - hcount increments.
  - At hcount = H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At vcount = V_TOTAL-1 with hcount = H_TOTAL-1, both wrap to 0.
- Reset: hcount = 0 and vcount = 0 on the next edge. A reset mid-frame restarts at pixel (0,0) with no partial-frame completion.
- All outputs are combinational decodes of the counters (zero latency relative to the counters):
  - active = (hcount < WIDTH) && (vcount < HEIGHT).
  - hSync = 0 iff WIDTH+H_FRONT <= hcount < WIDTH+H_FRONT+H_SYNC, i.e. 656..751; otherwise 1.
  - vSync = 0 iff HEIGHT+V_FRONT <= vcount < HEIGHT+V_FRONT+V_SYNC, i.e. 490..491; otherwise 1.
  - x = hcount (0..799). Consumers gate on active.
  - y = vcount when vcount < HEIGHT, else HEIGHT-1 (479). This keeps y within 9 bits and within the image.
  - screenEnd = 1 only when hcount = 0 and vcount = HEIGHT, i.e. exactly one clk25 cycle per frame.
- Output values after reset (counters at 0): active=1, hSync=1, vSync=1, x=0, y=0, screenEnd=0.
- Timing: frame period 800*525 = 420000 clk25 cycles; line period 800 cycles; 640 active cycles per visible line.
- No handshakes and no back-pressure; the generator free-runs.

Decomposition:
- Shared VGA package holds the timing constants: WIDTH, HEIGHT, porches, sync widths, H_TOTAL, V_TOTAL. The colour width (12) and the palette/pixel address widths live there too for the downstream RAM and mux.
- One natural sub-module: mod_counter, a parameterised wrap-at-N counter with enable and a wrap output. It is instantiated twice; the vertical instance is enabled by the horizontal wrap.

Test Plan:
- Reset: hold reset 3 cycles, release -> x=0, y=0, active=1, hSync=1, vSync=1, screenEnd=0.
- Line timing: from reset, count cycles.
  - active high for cycles 0..639 and low for 640..799.
  - hSync low exactly for hcount 656..751 (96 cycles).
  - x wraps 799->0 while y goes 0->1.
- Frame timing: run 420000 cycles.
  - vSync low exactly 1600 cycles, during lines 490..491.
  - y holds 479 for lines 480..524.
  - Counters return to (0,0) at cycle 420000.
- screenEnd: over 2 frames -> exactly 2 single-cycle pulses, at cycles 384000 and 804000 (hcount=0, vcount=480).
- Reset mid-frame: assert reset at hcount=300, vcount=200 -> next edge x=0, y=0. The next screenEnd occurs 384000 cycles after release.
- Active count: over one frame, active is high for exactly 307200 cycles.
